// File: rtl/corner_tracker_div_seq_28s_14s_if.sv
// rtl/corner_tracker_div_seq_28s_14s_if.sv - operand/result handshake bundle for the sequential signed divider
interface corner_tracker_div_seq_28s_14s_if #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 14
);
  logic                         in_valid;
  logic                         in_ready;
  logic signed [DIVIDEND_W-1:0] dividend;
  logic signed [DIVISOR_W-1:0]  divisor;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DIVIDEND_W-1:0] quotient;
  logic signed [DIVISOR_W-1:0]  remainder;
  logic                         dbz;
  logic                         ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dbz, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dbz, ovf
  );
endinterface

// File: rtl/corner_tracker_div_seq_28s_14s.sv
// rtl/corner_tracker_div_seq_28s_14s.sv - radix-2 restoring signed divider, 28s / 14s, CORNER_DIV_ROUND_EN selects round-to-nearest
module corner_tracker_div_seq_28s_14s #(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 14
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  corner_tracker_div_seq_28s_14s_if.slave bus
);
  localparam int NW = DIVIDEND_W + 1;
  localparam int RW = DIVISOR_W + 1;
  localparam int IW = $clog2(DIVIDEND_W);
  localparam logic [NW-1:0] QMAX_MAG = {2'b00, {(DIVIDEND_W-1){1'b1}}};
  localparam logic [NW-1:0] QMIN_MAG = {2'b01, {(DIVIDEND_W-1){1'b0}}};
  localparam logic [DIVIDEND_W-1:0] QMAX = {1'b0, {(DIVIDEND_W-1){1'b1}}};
  localparam logic [DIVIDEND_W-1:0] QMIN = {1'b1, {(DIVIDEND_W-1){1'b0}}};
  localparam logic [IW-1:0] ITER_TOP = IW'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                  state;
  logic [IW-1:0]           iter;
  logic [NW-1:0]           mag_n;
  logic [RW-1:0]           mag_d;
  logic [RW-1:0]           rem_r;
  logic [DIVIDEND_W-1:0]   q_r;
  logic                    sign_n;
  logic                    sign_d;
  logic                    d_zero;
  logic [DIVISOR_W-1:0]    dvd_low;

  logic                    in_ready_r;
  logic                    out_valid_r;
  logic [DIVIDEND_W-1:0]   quotient_r;
  logic [DIVISOR_W-1:0]    remainder_r;
  logic                    dbz_r;
  logic                    ovf_r;

  // One extra bit on both magnitudes so |MIN| of either operand is exact.
  logic [NW-1:0] in_n_ext;
  logic [NW-1:0] in_n_mag;
  logic [RW-1:0] in_d_ext;
  logic [RW-1:0] in_d_mag;

  assign in_n_ext = {bus.dividend[DIVIDEND_W-1], bus.dividend};
  assign in_n_mag = bus.dividend[DIVIDEND_W-1] ? -in_n_ext : in_n_ext;
  assign in_d_ext = {bus.divisor[DIVISOR_W-1], bus.divisor};
  assign in_d_mag = bus.divisor[DIVISOR_W-1] ? -in_d_ext : in_d_ext;

  logic [RW-1:0] rem_sh;
  logic          rem_ge;

  assign rem_sh = {rem_r[RW-2:0], mag_n[iter]};
  assign rem_ge = rem_sh >= mag_d;

  logic [NW-1:0] q_fin;
  logic [RW:0]   r_fin;
  logic [NW-1:0] q_signed;
  logic [RW:0]   r_signed;
  logic          q_neg;
  logic          q_sat;

`ifdef CORNER_DIV_ROUND_EN
  // Ties away from zero: bump |q| and pull the remainder across by one divisor.
  logic round_up;
  assign round_up = {rem_r, 1'b0} >= {1'b0, mag_d};
  assign q_fin    = {1'b0, q_r} + {{(NW-1){1'b0}}, round_up};
  assign r_fin    = round_up ? ({1'b0, rem_r} - {1'b0, mag_d}) : {1'b0, rem_r};
`else
  assign q_fin    = {1'b0, q_r};
  assign r_fin    = {1'b0, rem_r};
`endif

  assign q_neg    = sign_n ^ sign_d;
  assign q_signed = q_neg ? -q_fin : q_fin;
  assign r_signed = sign_n ? -r_fin : r_fin;
  assign q_sat    = q_neg ? (q_fin > QMIN_MAG) : (q_fin > QMAX_MAG);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      iter        <= '0;
      mag_n       <= '0;
      mag_d       <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      sign_n      <= 1'b0;
      sign_d      <= 1'b0;
      d_zero      <= 1'b0;
      dvd_low     <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (bus.in_valid && in_ready_r) begin
            in_ready_r <= 1'b0;
            mag_n      <= in_n_mag;
            mag_d      <= in_d_mag;
            sign_n     <= bus.dividend[DIVIDEND_W-1];
            sign_d     <= bus.divisor[DIVISOR_W-1];
            d_zero     <= (bus.divisor == '0);
            dvd_low    <= bus.dividend[DIVISOR_W-1:0];
            rem_r      <= '0;
            q_r        <= '0;
            iter       <= ITER_TOP;
            state      <= (bus.divisor == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          rem_r   <= rem_ge ? (rem_sh - mag_d) : rem_sh;
          q_r[iter] <= rem_ge;
          if (iter == '0) state <= FIX;
          else            iter  <= iter - 1'b1;
        end
        FIX: begin
          out_valid_r <= 1'b1;
          state       <= DONE;
          if (d_zero) begin
            quotient_r  <= sign_n ? QMIN : QMAX;
            remainder_r <= dvd_low;
            dbz_r       <= 1'b1;
            ovf_r       <= 1'b0;
          end else if (q_sat) begin
            quotient_r  <= q_neg ? QMIN : QMAX;
            remainder_r <= '0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b1;
          end else begin
            quotient_r  <= q_signed[DIVIDEND_W-1:0];
            remainder_r <= r_signed[DIVISOR_W-1:0];
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            dbz_r       <= 1'b0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;
  assign bus.dbz       = dbz_r;
  assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_corner_tracker_div_seq_28s_14s.sv
// tb/tb_corner_tracker_div_seq_28s_14s.sv - scoreboard bench for the sequential signed divider
module tb_corner_tracker_div_seq_28s_14s;
  localparam int QMAX = 134217727;
  localparam int QMIN = -134217728;

  logic clk = 1'b0;
  logic reset;
  logic ce;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  corner_tracker_div_seq_28s_14s_if #(.DIVIDEND_W(28), .DIVISOR_W(14)) bus ();

  corner_tracker_div_seq_28s_14s dut (
    .clk   (clk),
    .reset (reset),
    .ce    (ce),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int q;
    int r;
    int dbz;
    int ovf;
    int lat;
    int acc;
  } exp_t;

  typedef struct {
    int n;
    int d;
    int q;
    int r;
    int dbz;
    int ovf;
    int lat;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[$];
  logic prev_ov = 1'b0;

  function automatic void check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: compares the oldest expected result on every rising out_valid.
  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("quotient",  $signed(bus.quotient),  mon_e.q);
          check("remainder", $signed(bus.remainder), mon_e.r);
          check("dbz",       bus.dbz,                mon_e.dbz);
          check("ovf",       bus.ovf,                mon_e.ovf);
          check("latency",   cyc - mon_e.acc,        mon_e.lat);
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic issue(input vec_t v, output int acc);
    int k;
    k = 0;
    @(negedge clk);
    while (!(bus.in_ready && ce) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      check("issue_timeout", 0, 1);
      acc = -1;
    end else begin
      bus.in_valid = 1'b1;
      bus.dividend = 28'(v.n);
      bus.divisor  = 14'(v.d);
      acc = cyc;
      sb.push_back('{v.q, v.r, v.dbz, v.ovf, v.lat, acc});
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || bus.out_valid) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int acc_a;
    int acc_b;
    int k;
    int seen;

    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    ce            = 1'b1;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  bus.in_ready,  0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_quotient",  bus.quotient,  0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_dbz",       bus.dbz,       0);
    check("rst_ovf",       bus.ovf,       0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);

    vecs.push_back('{100, 7, 14, 2, 0, 0, 30});
    vecs.push_back('{-100, 7, -14, -2, 0, 0, 30});
    vecs.push_back('{100, -7, -14, 2, 0, 0, 30});
    vecs.push_back('{-100, -7, 14, -2, 0, 0, 30});
`ifdef CORNER_DIV_ROUND_EN
    vecs.push_back('{20, 8, 3, -4, 0, 0, 30});
    vecs.push_back('{-20, 8, -3, 4, 0, 0, 30});
    vecs.push_back('{QMAX, -8192, -16384, -1, 0, 0, 30});
`else
    vecs.push_back('{20, 8, 2, 4, 0, 0, 30});
    vecs.push_back('{-20, 8, -2, -4, 0, 0, 30});
    vecs.push_back('{QMAX, -8192, -16383, 8191, 0, 0, 30});
`endif
    vecs.push_back('{5, 0, QMAX, 5, 1, 0, 2});
    vecs.push_back('{-5, 0, QMIN, -5, 1, 0, 2});
    vecs.push_back('{QMIN, -1, QMAX, 0, 0, 1, 30});
    vecs.push_back('{QMIN, 1, QMIN, 0, 0, 0, 30});
    vecs.push_back('{0, 5, 0, 0, 0, 0, 30});

    foreach (vecs[i]) begin
      issue(vecs[i], acc_a);
      drain();
    end

    // Back-to-back operations: spacing set by the IDLE re-entry cycle.
    issue('{1000, 3, 333, 1, 0, 0, 30}, acc_a);
    issue('{-999, 10, -99, -9, 0, 0, 30}, acc_b);
    check("throughput", acc_b - acc_a, 31);
    drain();

    // ce low 3 cycles mid-CALC and out_ready held low 5 cycles in DONE.
    bus.out_ready = 1'b0;
    issue('{100, 7, 14, 2, 0, 0, 33}, acc_a);
    repeat (9) @(negedge clk);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    ce = 1'b1;
    k = 0;
    while (!bus.out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("stall_timeout", 0, 1);
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_in_ready",  bus.in_ready,  0);
      check("stall_quotient",  $signed(bus.quotient),  14);
      check("stall_remainder", $signed(bus.remainder), 2);
    end
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of CALC discards the operation.
    issue('{100, 7, 14, 2, 0, 0, 30}, acc_a);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_in_ready_low", bus.in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready_high", bus.in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("midrst_no_out_valid", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
